// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready front-end for a single-port SRAM with 1-cycle
// registered read data. Responses return in order through a bypass path or a
// small FIFO. Request acceptance is credit-gated, so every response is
// guaranteed a slot.
// Optional feature: define SRAM_CTRL_WR_ACK_EN to make writes return an ack
// response (resp_is_write = 1, resp_rdata = 0).
module sram_req_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_is_write,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_re,
    output logic                  sram_we,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;

    logic                  fire;
    logic                  produce;
    logic                  push;
    logic                  pop;
    logic [CW:0]           pending;
    logic [DATA_WIDTH-1:0] in_data;

    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] data_mem_q [RESP_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [RESP_DEPTH];
`ifdef SRAM_CTRL_WR_ACK_EN
    logic                  inflight_wr_q, inflight_wr_d;
    logic                  iswr_mem_q [RESP_DEPTH];
    logic                  iswr_mem_d [RESP_DEPTH];
`endif

    // Credit check and SRAM pin drive; ready depends on registered state only
    always_comb begin
        pending    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        req_ready  = rst_n && (pending < (CW+1)'(RESP_DEPTH));
        fire       = req_valid && req_ready;
        sram_addr  = req_addr;
        sram_wdata = req_wdata;
        sram_re    = fire && !req_we;
        sram_we    = fire && req_we;
`ifdef SRAM_CTRL_WR_ACK_EN
        produce    = fire;
        in_data    = inflight_wr_q ? '0 : sram_rdata;
`else
        produce    = fire && !req_we;
        in_data    = sram_rdata;
`endif
    end

    // Response mux: FIFO head has priority, otherwise the fresh SRAM data bypasses
    always_comb begin
        resp_valid = 1'b0;
        resp_rdata = '0;
`ifdef SRAM_CTRL_WR_ACK_EN
        resp_is_write = 1'b0;
`endif
        if (count_q != '0) begin
            resp_valid = 1'b1;
            resp_rdata = data_mem_q[rd_ptr_q];
`ifdef SRAM_CTRL_WR_ACK_EN
            resp_is_write = iswr_mem_q[rd_ptr_q];
`endif
        end else if (inflight_q) begin
            resp_valid = 1'b1;
            resp_rdata = in_data;
`ifdef SRAM_CTRL_WR_ACK_EN
            resp_is_write = inflight_wr_q;
`endif
        end
    end

`ifndef SRAM_CTRL_WR_ACK_EN
    assign resp_is_write = 1'b0;
`endif

    // FIFO bookkeeping: push unless the bypassed response is taken immediately
    always_comb begin
        push       = inflight_q && !((count_q == '0) && resp_ready);
        pop        = resp_ready && (count_q != '0);
        inflight_d = produce;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_mem_d = data_mem_q;
`ifdef SRAM_CTRL_WR_ACK_EN
        inflight_wr_d = fire && req_we;
        iswr_mem_d    = iswr_mem_q;
`endif
        if (push) begin
            data_mem_d[wr_ptr_q] = in_data;
`ifdef SRAM_CTRL_WR_ACK_EN
            iswr_mem_d[wr_ptr_q] = inflight_wr_q;
`endif
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
`ifdef SRAM_CTRL_WR_ACK_EN
            inflight_wr_q <= 1'b0;
`endif
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
`ifdef SRAM_CTRL_WR_ACK_EN
            inflight_wr_q <= inflight_wr_d;
`endif
        end
    end

    // FIFO storage is data only; validity is carried by count_q
    always_ff @(posedge clk) begin
        data_mem_q <= data_mem_d;
`ifdef SRAM_CTRL_WR_ACK_EN
        iswr_mem_q <= iswr_mem_d;
`endif
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Testbench for sram_req_ctrl with a behavioural 1-cycle-latency SRAM and
// an in-order response scoreboard.
module tb_sram_req_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_is_write;
    logic [3:0]  sram_addr;
    logic        sram_re;
    logic        sram_we;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int tests = 0;
    int fails = 0;
    logic [32:0] exp_q [$];
    logic [31:0] sram_mem [16];

    always #5 clk = ~clk;

    sram_req_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RESP_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_is_write(resp_is_write),
        .sram_addr(sram_addr), .sram_re(sram_re), .sram_we(sram_we),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // Behavioural SRAM: clears on reset, registered read data
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) sram_mem[i] <= '0;
            sram_rdata <= '0;
        end else begin
            if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            if (sram_re) sram_rdata <= sram_mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        if (rst_n && (sram_re || sram_we))
            check("re_we_exclusive", {32'd0, sram_re && sram_we}, 33'd0);
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {resp_is_write, resp_rdata}, 33'h1_FFFF_FFFF);
            end else begin
                check("resp", {resp_is_write, resp_rdata}, exp_q.pop_front());
            end
        end
    end

    // Drive one request starting at posedge+1; returns after its fire edge (+1)
    task automatic send(input logic we, input logic [3:0] a, input logic [31:0] d, output int waits);
        logic rdy;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        waits = 0;
        forever begin
            @(negedge clk); rdy = req_ready;
            @(posedge clk); #1;
            if (rdy) break;
            waits++;
            if (waits >= 50) begin
                check("req_ready_timeout", 33'd0, 33'd1);
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Expectation for a write: an ack only when write acks are enabled
    task automatic exp_write();
`ifdef SRAM_CTRL_WR_ACK_EN
        exp_q.push_back({1'b1, 32'd0});
`endif
    endtask

    initial begin
        int w;
        rst_n = 1'b0; resp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 32'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {32'd0, req_ready}, 33'd0);
        check("rst_resp_valid", {32'd0, resp_valid}, 33'd0);
        check("rst_resp_rdata", {1'b0, resp_rdata}, 33'd0);
        check("rst_resp_is_write", {32'd0, resp_is_write}, 33'd0);
        check("rst_sram_we", {32'd0, sram_we}, 33'd0);
        check("rst_sram_re", {32'd0, sram_re}, 33'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid = 1'b0;
        idle_cycles(1);

        // Write then read back, with latency check
        exp_write();
        send(1'b1, 4'd3, 32'hDEADBEEF, w);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        send(1'b0, 4'd3, 32'd0, w);
        req_valid = 1'b0;
        @(negedge clk);
        check("rd_latency_valid", {32'd0, resp_valid}, 33'd1);
        check("rd_latency_data", {1'b0, resp_rdata}, {1'b0, 32'hDEADBEEF});
        @(posedge clk); #1;
        idle_cycles(3);

        // Preload 0x10..0x13, then four back-to-back reads
        for (int i = 0; i < 4; i++) begin
            exp_write();
            send(1'b1, 4'(i), 32'h10 + 32'(i), w);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, 32'h10 + 32'(i)});
            send(1'b0, 4'(i), 32'd0, w);
            check("b2b_no_stall", 33'(w), 33'd0);
        end
        idle_cycles(4);

        // Backpressure: fill credits, then drain
        exp_write(); send(1'b1, 4'd1, 32'hA1, w);
        exp_write(); send(1'b1, 4'd2, 32'hA2, w);
        idle_cycles(3);
        resp_ready = 1'b0;
        exp_q.push_back({1'b0, 32'hA1});
        send(1'b0, 4'd1, 32'd0, w);
        exp_q.push_back({1'b0, 32'hA2});
        send(1'b0, 4'd2, 32'd0, w);
        req_valid = 1'b0;
        @(negedge clk);
        check("full_ready_low", {32'd0, req_ready}, 33'd0);
        check("held_head", {resp_is_write, resp_rdata}, {1'b0, 32'hA1});
        @(posedge clk); #1;
        @(negedge clk);
        check("full_ready_low2", {32'd0, req_ready}, 33'd0);
        check("held_head_stable", {resp_is_write, resp_rdata}, {1'b0, 32'hA1});
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("ready_low_in_pop_cycle", {32'd0, req_ready}, 33'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_back_after_pop", {32'd0, req_ready}, 33'd1);
        @(posedge clk); #1;
        idle_cycles(3);

        // Reset mid-operation with one buffered and one in-flight read
        resp_ready = 1'b0;
        send(1'b0, 4'd0, 32'd0, w);
        idle_cycles(1);
        send(1'b0, 4'd1, 32'd0, w);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_resp_valid", {32'd0, resp_valid}, 33'd0);
        check("midrst_req_ready", {32'd0, req_ready}, 33'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; resp_ready = 1'b1;
        idle_cycles(1);
        exp_q.push_back({1'b0, 32'd0});
        send(1'b0, 4'd3, 32'd0, w);
        idle_cycles(3);

        // Write 0x55 to addr 7, read it back
        exp_write();
        send(1'b1, 4'd7, 32'h55, w);
        exp_q.push_back({1'b0, 32'h55});
        send(1'b0, 4'd7, 32'd0, w);
        idle_cycles(5);

        check("scoreboard_drained", 33'(exp_q.size()), 33'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
